// File: rtl/logica_pkg.sv
// Shared opcode definitions for the registered bitwise logic unit.
package logica_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_NOT  = 3'd1,
        OP_NAND = 3'd2,
        OP_OR   = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/logica_comb.sv
// Combinational gate selector: one WIDTH-bit bitwise function chosen by opcode.
module logica_comb
    import logica_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_op)
            OP_AND:  o_y = i_a & i_b;
            OP_NOT:  o_y = ~i_a;
            OP_NAND: o_y = ~(i_a & i_b);
            OP_OR:   o_y = i_a | i_b;
            OP_NOR:  o_y = ~(i_a | i_b);
            OP_XOR:  o_y = i_a ^ i_b;
            OP_XNOR: o_y = ~(i_a ^ i_b);
            OP_PASS: o_y = i_a;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/unidad_logica_reg.sv
// Registered logic unit: valid/ready output stage, accumulator operand,
// zero/parity flags and completed-transaction counter.
module unidad_logica_reg
    import logica_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc_sel,
    input  logic             in_acc_wr,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_par,
    output logic [WIDTH-1:0] acc_q,
    output logic [CNT_W-1:0] tx_count
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_y;
    logic             r_out_zero;
    logic             r_out_par;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_tx_count;

    logic             w_accept;
    logic [WIDTH-1:0] w_bsel;
    logic [WIDTH-1:0] w_result;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_bsel   = in_acc_sel ? r_acc : in_b;

    logica_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .i_op (op_e'(in_op)),
        .i_a  (in_a),
        .i_b  (w_bsel),
        .o_y  (w_result)
    );

    // Output stage: result and flags only change on accept, so they hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_zero  <= 1'b0;
            r_out_par   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_y     <= w_result;
            r_out_zero  <= (w_result == '0);
            r_out_par   <= ^w_result;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Clear wins over a same-edge write; the result itself already used the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (acc_clr) begin
            r_acc <= '0;
        end else if (w_accept && in_acc_wr) begin
            r_acc <= w_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_count <= '0;
        end else if (r_out_valid && out_ready) begin
            r_tx_count <= r_tx_count + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_zero  = r_out_zero;
    assign out_par   = r_out_par;
    assign acc_q     = r_acc;
    assign tx_count  = r_tx_count;

endmodule
